// File: rtl/iiitb_bc_pkg.sv
// -----------------------------------------------------------------------------
// iiitb_bc_pkg
// Shared definitions for the iiitb_bc 4-bit up/down counter and its direction
// controller.
//   db_state_e : button debounce FSM states
//   BC_*       : counter width, terminal value and auto-reverse turn points
//   next_dir   : direction-update rule (press toggle plus auto-reverse)
// -----------------------------------------------------------------------------
package iiitb_bc_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_e;

  localparam int                 BC_WIDTH   = 4;
  localparam logic [BC_WIDTH-1:0] BC_MAX     = 4'hF;
  localparam logic [BC_WIDTH-1:0] BC_TURN_UP = 4'hE;
  localparam logic [BC_WIDTH-1:0] BC_TURN_DN = 4'h1;

  // The turn points are one short of the ends because the counter moves on
  // the same edge: turning while Count=14 makes the next Count 15, after
  // which the counter heads down. Auto-reverse overrides (and consumes) a
  // press landing on the same edge.
  function automatic logic next_dir(input logic                dir,
                                    input logic                press,
                                    input logic                auto_en,
                                    input logic [BC_WIDTH-1:0] cnt);
    logic nd;
    nd = press ? ~dir : dir;
    if (auto_en && dir && (cnt == BC_TURN_UP)) begin
      nd = 1'b0;
    end else if (auto_en && !dir && (cnt == BC_TURN_DN)) begin
      nd = 1'b1;
    end
    return nd;
  endfunction

endpackage

// File: rtl/iiitb_bc_dir_ctrl_if.sv
// -----------------------------------------------------------------------------
// iiitb_bc_dir_ctrl_if
// Signal bundle between the direction controller and its environment.
//   btn_raw     : asynchronous push-button, active-high, may bounce
//   auto_mode   : 1 = auto-reverse at the count ends
//   Count       : feedback from iiitb_bc.Count
//   UpOrDown    : direction to iiitb_bc (1 = up)
//   dir_changed : one-cycle pulse when UpOrDown takes a new value
// master = environment side, slave = controller side.
// -----------------------------------------------------------------------------
interface iiitb_bc_dir_ctrl_if;
  import iiitb_bc_pkg::*;

  logic                btn_raw;
  logic                auto_mode;
  logic [BC_WIDTH-1:0] Count;
  logic                UpOrDown;
  logic                dir_changed;

  modport master (
    output btn_raw,
    output auto_mode,
    output Count,
    input  UpOrDown,
    input  dir_changed
  );

  modport slave (
    input  btn_raw,
    input  auto_mode,
    input  Count,
    output UpOrDown,
    output dir_changed
  );

endinterface

// File: rtl/iiitb_bc_debounce.sv
// -----------------------------------------------------------------------------
// iiitb_bc_debounce
// Two-flop synchronizer followed by a press/release debounce FSM. press_evt
// is a single-cycle strobe asserted on the edge the FSM accepts a press
// (DB_PRESS -> HELD); holding the button never repeats it.
//   Clk       : clock, rising edge
//   reset     : synchronous, active-high
//   btn_raw   : asynchronous button input
//   press_evt : accepted-press strobe, combinational from the FSM so the
//               consumer registers it on the same edge the FSM moves to HELD
// Parameter DEBOUNCE_CYCLES (1..255): stable synchronized cycles required.
// -----------------------------------------------------------------------------
module iiitb_bc_debounce
  import iiitb_bc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_evt
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic      sync1_q;
  logic      btn_s_q;
  db_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge Clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= btn_raw;
      btn_s_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = DB_PRESS;
          cnt_d   = 8'd1;
        end
      end
      DB_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == DB_LIMIT) begin
          state_d   = HELD;
          cnt_d     = 8'd0;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = DB_RELEASE;
          cnt_d   = 8'd1;
        end
      end
      DB_RELEASE: begin
        // A glitch high while releasing returns to HELD without a new event.
        if (btn_s_q) begin
          state_d = HELD;
          cnt_d   = 8'd0;
        end else if (cnt_q == DB_LIMIT) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

endmodule

// File: rtl/iiitb_bc_dir_ctrl.sv
// -----------------------------------------------------------------------------
// iiitb_bc_dir_ctrl
// Generates iiitb_bc.UpOrDown. Each debounced press toggles the direction;
// with auto_mode set the direction also reverses at the count ends so the
// counter bounces 0..15..0 instead of wrapping.
//   Clk   : clock, rising edge
//   reset : synchronous, active-high (shared with iiitb_bc)
//   bus   : slave side of iiitb_bc_dir_ctrl_if
//           (btn_raw, auto_mode, Count in; UpOrDown, dir_changed out)
// Parameter DEBOUNCE_CYCLES (1..255): passed to the debouncer.
// -----------------------------------------------------------------------------
module iiitb_bc_dir_ctrl
  import iiitb_bc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                reset,
  iiitb_bc_dir_ctrl_if.slave  bus
);

  logic press_evt;
  logic dir_q, dir_d;
  logic chg_q, chg_d;

  iiitb_bc_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clk       (Clk),
    .reset     (reset),
    .btn_raw   (bus.btn_raw),
    .press_evt (press_evt)
  );

  // Auto-reverse looks at the current Count, so the turn lands on the same
  // edge the counter reaches its end value.
  always_comb begin
    dir_d = next_dir(dir_q, press_evt, bus.auto_mode, bus.Count);
    chg_d = (dir_d != dir_q);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      dir_q <= 1'b1;
      chg_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      chg_q <= chg_d;
    end
  end

  assign bus.UpOrDown    = dir_q;
  assign bus.dir_changed = chg_q;

endmodule

// File: tb/tb_iiitb_bc_dir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iiitb_bc_dir_ctrl
// Drives iiitb_bc_dir_ctrl with an in-bench iiitb_bc counter closing the
// Count feedback loop. A reference model built around run lengths of the
// synchronized button (a press is accepted after DEBOUNCE_CYCLES+1
// consecutive high samples, a release after as many low samples) pushes the
// expected UpOrDown / dir_changed / Count every edge; a monitor on the
// falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_iiitb_bc_dir_ctrl;
  import iiitb_bc_pkg::*;

  localparam int unsigned DB = 4;

  logic Clk;
  logic reset;

  iiitb_bc_dir_ctrl_if bus ();

  iiitb_bc_dir_ctrl #(
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // iiitb_bc: 4-bit up/down counter, wraps, sync reset to 0.
  logic [3:0] bc_count;
  always @(posedge Clk) begin
    if (reset) bc_count <= 4'd0;
    else if (bus.UpOrDown) bc_count <= bc_count + 4'd1;
    else bc_count <= bc_count - 4'd1;
  end
  assign bus.Count = bc_count;

  typedef struct packed {
    logic       dir;
    logic       chg;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- reference model ----------------
  bit m_s1, m_s2;       // button as seen two edges later
  bit m_pressed;        // debounced level
  int m_run;            // consecutive samples disagreeing with m_pressed
  bit m_dir;
  bit m_chg;
  int m_cnt;            // 0..15

  always @(posedge Clk) begin
    bit press;
    bit nd;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_pressed = 0; m_run = 0;
      m_dir = 1; m_chg = 0; m_cnt = 0;
    end else begin
      press = 0;
      if (m_s2 != m_pressed) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_pressed = m_s2;
          m_run = 0;
          press = m_s2;
        end
      end else begin
        m_run = 0;
      end
      nd = press ? !m_dir : m_dir;
      if (bus.auto_mode) begin
        if (m_dir && m_cnt == 14) nd = 0;
        if (!m_dir && m_cnt == 1) nd = 1;
      end
      m_cnt = m_dir ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
      m_chg = (nd != m_dir);
      m_dir = nd;
      m_s2 = m_s1;
      m_s1 = bus.btn_raw;
    end
    exp_q.push_back('{dir: m_dir, chg: m_chg, cnt: 4'(m_cnt)});
  end

  // ---------------- monitor ----------------
  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("UpOrDown",    int'(bus.UpOrDown),    int'(e.dir));
      check("dir_changed", int'(bus.dir_changed), int'(e.chg));
      check("Count",       int'(bc_count),        int'(e.cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  int pulses;
  always @(negedge Clk) if (bus.dir_changed === 1'b1) pulses++;

  initial begin
    int got_pulses;
    bit found;
    reset = 1'b1;
    bus.btn_raw = 1'b0;
    bus.auto_mode = 1'b0;
    pulses = 0;
    tick(3);
    reset = 1'b0;
    tick(20);                       // free run, wraps 15 -> 0

    // Clean press held 10 cycles: exactly one toggle, none on release.
    got_pulses = pulses;
    bus.btn_raw = 1'b1; tick(10);
    bus.btn_raw = 1'b0; tick(12);
    check("clean_press_pulses", pulses - got_pulses, 1);

    // Bounce 1-0-1-0 then stable high: one toggle.
    got_pulses = pulses;
    bus.btn_raw = 1'b1; tick(1);
    bus.btn_raw = 1'b0; tick(1);
    bus.btn_raw = 1'b1; tick(1);
    bus.btn_raw = 1'b0; tick(1);
    bus.btn_raw = 1'b1; tick(12);
    bus.btn_raw = 1'b0; tick(12);
    check("bounce_pulses", pulses - got_pulses, 1);

    // Auto mode from reset: bounces between the ends.
    reset = 1'b1; bus.auto_mode = 1'b1; tick(2);
    reset = 1'b0; tick(40);

    // Press accepted on the edge where Count=14 going up.
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (bc_count == 4'd8 && bus.UpOrDown) found = 1;
      else tick(1);
    end
    check("wait_count8_up", int'(found), 1);
    got_pulses = pulses;
    bus.btn_raw = 1'b1; tick(10);
    check("press_at_turn_pulses", pulses - got_pulses, 1);
    bus.btn_raw = 1'b0; tick(12);

    // Reset while debouncing; button still held afterwards is a new press.
    bus.auto_mode = 1'b0;
    reset = 1'b1; tick(1); reset = 1'b0;
    bus.btn_raw = 1'b1; tick(5);
    reset = 1'b1; tick(2);
    reset = 1'b0;
    check("dir_after_reset", int'(bus.UpOrDown), 1);
    tick(10);
    bus.btn_raw = 1'b0; tick(12);

    // Randomized button activity, mode flips and occasional resets.
    for (int i = 0; i < 300; i++) begin
      bus.btn_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.auto_mode = ~bus.auto_mode;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1; tick(1); reset = 1'b0;
      end
      tick($urandom_range(1, 9));
    end
    bus.btn_raw = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
